// File: rtl/counter_sequencer.sv
// Push-button / switch front end for the up/down counter: synchronizes and debounces
// the keys, then issues step pulses, run-mode ticks with optional bounce, and clears.
//
// state | meaning
// IDLE  | waiting; a key press gives a step pulse (step mode) or starts RUN (run mode)
// RUN   | periodic count pulses from the prescaler, optional auto-reverse at limits
// CLEAR | one-cycle active-low clear to the counter
// HOLD  | both keys still down after a clear; wait for both to be released
module counter_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 12500000
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             key_up_n,
    input  logic             key_down_n,
    input  logic             mode_run,
    input  logic             bounce,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic             cnt_clear_n,
    output logic [1:0]       state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LOAD  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LOAD = PW'(TICK_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    // bit 0 = up key, 1 = down key, 2 = run switch, 3 = bounce switch (keys as "pressed")
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [1:0]    key_lvl;
    logic [1:0]    key_lvl_d;
    logic [DW-1:0] deb_cnt [2];
    logic [PW-1:0] presc;

    logic [1:0]    state_nxt;
    logic          enable_nxt;
    logic          dir_nxt;
    logic          clear_n_nxt;
    logic [PW-1:0] presc_nxt;

    logic up_press;
    logic down_press;
    logic both_held;
    logic mode_s;
    logic bounce_s;
    logic tick;
    logic at_limit;
    logic dir_match;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bounce, mode_run, ~key_down_n, ~key_up_n};
            sync2 <= sync1;
        end
    end

    // Down-counter reloads whenever the synchronized level agrees; expiry accepts the new level.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            key_lvl   <= '0;
            key_lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= DEB_LOAD;
            end
        end else begin
            key_lvl_d <= key_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == key_lvl[i]) begin
                    deb_cnt[i] <= DEB_LOAD;
                end else if (deb_cnt[i] == '0) begin
                    key_lvl[i] <= sync2[i];
                    deb_cnt[i] <= DEB_LOAD;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] - DW'(1);
                end
            end
        end
    end

    assign up_press   = key_lvl[0] & ~key_lvl_d[0];
    assign down_press = key_lvl[1] & ~key_lvl_d[1];
    assign both_held  = key_lvl[0] & key_lvl[1];
    assign mode_s     = sync2[2];
    assign bounce_s   = sync2[3];
    assign tick       = (presc == '0);
    assign at_limit   = cnt_up_down ? (count_in == {WIDTH{1'b1}}) : (count_in == '0);
    assign dir_match  = cnt_up_down ? up_press : down_press;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt_enable  <= 1'b0;
            cnt_up_down <= 1'b1;
            cnt_clear_n <= 1'b1;
            presc       <= '0;
        end else begin
            state       <= state_nxt;
            cnt_enable  <= enable_nxt;
            cnt_up_down <= dir_nxt;
            cnt_clear_n <= clear_n_nxt;
            presc       <= presc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (both_held) begin
                    state_nxt = CLEAR;
                end else if ((up_press | down_press) & mode_s) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (both_held) begin
                    state_nxt = CLEAR;
                end else if (!mode_s || dir_match) begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: state_nxt = HOLD;
            HOLD: begin
                if (key_lvl == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enable_nxt  = 1'b0;
        dir_nxt     = cnt_up_down;
        clear_n_nxt = 1'b1;
        presc_nxt   = presc;
        case (state)
            IDLE: begin
                if (both_held) begin
                    clear_n_nxt = 1'b0;
                end else if (up_press | down_press) begin
                    dir_nxt = up_press;
                    if (mode_s) begin
                        presc_nxt = TICK_LOAD;
                    end else begin
                        enable_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (both_held) begin
                    clear_n_nxt = 1'b0;
                end else if (mode_s && !dir_match) begin
                    if (up_press | down_press) begin
                        dir_nxt   = ~cnt_up_down;
                        presc_nxt = TICK_LOAD;
                    end else if (tick) begin
                        // Reverse in the same cycle so this pulse already counts away from the limit.
                        enable_nxt = 1'b1;
                        presc_nxt  = TICK_LOAD;
                        if (bounce_s && at_limit) begin
                            dir_nxt = ~cnt_up_down;
                        end
                    end else begin
                        presc_nxt = presc - PW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios with hand-derived timing plus a random
// phase, all compared every cycle against a cycle-count based behavioural model.
module tb_counter_sequencer;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
    localparam int TICK  = 8;
    localparam logic [WIDTH-1:0] MAXC = '1;

    logic             CLOCK = 1'b0;
    logic             reset;
    logic             key_up_n;
    logic             key_down_n;
    logic             mode_run;
    logic             bounce;
    logic [WIDTH-1:0] count_in;
    logic             cnt_enable;
    logic             cnt_up_down;
    logic             cnt_clear_n;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES(TICK)
    ) dut (
        .CLOCK(CLOCK),
        .reset(reset),
        .key_up_n(key_up_n),
        .key_down_n(key_down_n),
        .mode_run(mode_run),
        .bounce(bounce),
        .count_in(count_in),
        .cnt_enable(cnt_enable),
        .cnt_up_down(cnt_up_down),
        .cnt_clear_n(cnt_clear_n),
        .state(state)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sync delay as a 2-deep history, debounce as a run length of
    // disagreeing samples, run-mode ticks as absolute cycle numbers.
    int  m_state;
    bit  m_en, m_dir, m_clr;
    bit  m_s1 [4];
    bit  m_s2 [4];
    bit  m_deb [2];
    bit  m_debp [2];
    int  m_run [2];
    int  m_cyc, m_next_tick;

    always @(posedge CLOCK or negedge reset) begin : model
        bit pu, pd, both;
        if (!reset) begin
            m_state = 0; m_en = 0; m_dir = 1; m_clr = 1;
            m_cyc = 0; m_next_tick = 0;
            for (int k = 0; k < 4; k++) begin m_s1[k] = 0; m_s2[k] = 0; end
            for (int k = 0; k < 2; k++) begin m_deb[k] = 0; m_debp[k] = 0; m_run[k] = 0; end
        end else begin
            pu   = m_deb[0] && !m_debp[0];
            pd   = m_deb[1] && !m_debp[1];
            both = m_deb[0] && m_deb[1];
            m_en  = 0;
            m_clr = 1;
            case (m_state)
                0: begin
                    if (both) begin
                        m_state = 2; m_clr = 0;
                    end else if (pu || pd) begin
                        m_dir = pu;
                        if (m_s2[2]) begin
                            m_state = 1; m_next_tick = m_cyc + TICK;
                        end else begin
                            m_en = 1;
                        end
                    end
                end
                1: begin
                    if (both) begin
                        m_state = 2; m_clr = 0;
                    end else if (!m_s2[2]) begin
                        m_state = 0;
                    end else if ((pu && m_dir) || (pd && !m_dir)) begin
                        m_state = 0;
                    end else if (pu || pd) begin
                        m_dir = !m_dir; m_next_tick = m_cyc + TICK;
                    end else if (m_cyc == m_next_tick) begin
                        m_en = 1; m_next_tick = m_cyc + TICK;
                        if (m_s2[3] && ((m_dir && count_in == MAXC) || (!m_dir && count_in == '0)))
                            m_dir = !m_dir;
                    end
                end
                2: m_state = 3;
                default: if (!m_deb[0] && !m_deb[1]) m_state = 0;
            endcase
            for (int k = 0; k < 2; k++) begin
                m_debp[k] = m_deb[k];
                if (m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_deb[k] = m_s2[k]; m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            for (int k = 0; k < 4; k++) m_s2[k] = m_s1[k];
            m_s1[0] = !key_up_n; m_s1[1] = !key_down_n; m_s1[2] = mode_run; m_s1[3] = bounce;
            m_cyc++;
        end
    end

    always @(negedge CLOCK) begin
        #1;
        check("enable", cnt_enable, m_en);
        check("up_down", cnt_up_down, m_dir);
        check("clear_n", cnt_clear_n, m_clr);
        check("state", state, m_state);
        check("enable_in_clear", cnt_enable & ~cnt_clear_n, 0);
    end

    int o_first, o_second, o_ud1, o_ud2, o_pulses, o_clr, o_en_clr;
    int o_run, o_clear, o_hold, o_idle, o_down;

    // Watch n cycles; index i is the i-th falling edge after the call. Keys released at rel.
    task automatic observe(input int n, input int rel);
        o_first = -1; o_second = -1; o_ud1 = -1; o_ud2 = -1; o_pulses = 0;
        o_clr = 0; o_en_clr = 0; o_run = -1; o_clear = -1; o_hold = -1; o_idle = -1; o_down = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLOCK);
            if (i == rel) begin key_up_n = 1; key_down_n = 1; end
            if (cnt_enable) begin
                o_pulses++;
                if (o_first < 0) begin o_first = i; o_ud1 = cnt_up_down; end
                else if (o_second < 0) begin o_second = i; o_ud2 = cnt_up_down; end
            end
            if (!cnt_clear_n) begin o_clr++; if (cnt_enable) o_en_clr++; end
            if (state == 2'd1 && o_run < 0) o_run = i;
            if (state == 2'd2 && o_clear < 0) o_clear = i;
            if (state == 2'd3 && o_hold < 0) o_hold = i;
            if (state == 2'd0 && o_idle < 0) o_idle = i;
            if (!cnt_up_down && o_down < 0) o_down = i;
        end
    endtask

    initial begin
        int g;
        int hold_up, hold_dn;
        reset = 0; key_up_n = 1; key_down_n = 1; mode_run = 0; bounce = 0; count_in = '0;
        repeat (3) @(negedge CLOCK);
        check("rst_enable", cnt_enable, 0);
        check("rst_up_down", cnt_up_down, 1);
        check("rst_clear_n", cnt_clear_n, 1);
        check("rst_state", state, 0);
        reset = 1;
        observe(6, 0);

        // step mode
        key_up_n = 0;
        observe(20, 20);
        check("step_up_latency", o_first, 7);
        check("step_up_pulses", o_pulses, 1);
        check("step_up_dir", o_ud1, 1);
        observe(12, 0);
        check("step_release_pulses", o_pulses, 0);
        key_up_n = 0;
        observe(3, 3);
        g = o_pulses;
        observe(15, 0);
        check("glitch_pulses", g + o_pulses, 0);
        key_down_n = 0;
        observe(20, 20);
        check("step_down_latency", o_first, 7);
        check("step_down_dir", o_ud1, 0);
        check("step_down_pulses", o_pulses, 1);
        observe(12, 0);

        // run mode
        mode_run = 1;
        observe(4, 0);
        key_up_n = 0;
        observe(40, 10);
        check("run_entry", o_run, 7);
        check("run_first_pulse", o_first, 15);
        check("run_second_pulse", o_second, 23);
        key_up_n = 0;
        observe(20, 10);
        check("run_exit", o_idle, 7);
        observe(20, 0);
        check("idle_no_pulses", o_pulses, 0);
        check("idle_state", state, 0);

        // bounce at both limits
        bounce = 1; count_in = MAXC;
        observe(3, 0);
        key_up_n = 0;
        observe(20, 10);
        check("bounce_entry", o_run, 7);
        check("bounce_top_pulse", o_first, 15);
        check("bounce_top_dir", o_ud1, 0);
        count_in = '0;
        observe(12, 0);
        check("bounce_bot_pulse", o_first, 3);
        check("bounce_bot_dir", o_ud1, 1);
        check("after_bounce_pulse", o_second, 11);
        check("after_bounce_dir", o_ud2, 1);

        // reversal by opposite key
        bounce = 0; count_in = 8'd100;
        key_down_n = 0;
        observe(30, 10);
        check("reverse_latency", o_down, 7);
        check("reverse_pulse", o_first, 15);
        check("reverse_dir", o_ud1, 0);
        check("reverse_state", state, 1);

        // both keys: clear then hold
        key_up_n = 0; key_down_n = 0;
        observe(20, 0);
        check("clear_entry", o_clear, 7);
        check("hold_entry", o_hold, 8);
        check("clear_cycles", o_clr, 1);
        check("clear_enable", o_en_clr, 0);
        check("hold_state", state, 3);
        key_up_n = 1; key_down_n = 1;
        observe(15, 0);
        check("hold_release", o_idle, 7);

        // async reset mid-RUN (down direction so up_down visibly resets)
        key_down_n = 0;
        observe(12, 10);
        check("down_run_entry", o_run, 7);
        observe(5, 0);
        @(posedge CLOCK);
        #3 reset = 0;
        #1;
        check("async_enable", cnt_enable, 0);
        check("async_up_down", cnt_up_down, 1);
        check("async_clear_n", cnt_clear_n, 1);
        check("async_state", state, 0);
        repeat (2) @(negedge CLOCK);
        reset = 1;
        observe(30, 0);
        check("post_reset_pulses", o_pulses, 0);
        check("post_reset_run", o_run, -1);

        // random phase
        hold_up = 0; hold_dn = 0; bounce = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK);
            if (i == 1500) begin
                @(posedge CLOCK);
                #3 reset = 0;
                @(negedge CLOCK);
                reset = 1;
            end
            if (hold_up == 0) begin
                key_up_n = 1'($urandom_range(0, 1)); hold_up = $urandom_range(1, 16);
            end else hold_up--;
            if (hold_dn == 0) begin
                key_down_n = 1'($urandom_range(0, 1)); hold_dn = $urandom_range(1, 16);
            end else hold_dn--;
            if ($urandom_range(0, 149) == 0) mode_run = ~mode_run;
            if ($urandom_range(0, 99) == 0) bounce = ~bounce;
            case ($urandom_range(0, 3))
                0: count_in = '0;
                1: count_in = MAXC;
                default: count_in = WIDTH'($urandom);
            endcase
        end
        repeat (3) @(negedge CLOCK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that drives the 8-bit up/down counter from two board push-buttons (KEY[0] = up, KEY[1] = down) and two slide switches. It synchronizes and debounces the keys, then generates the counter's enable, direction and clear controls. Step mode issues one count per press. Run mode counts continuously at a prescaled tick rate, with optional bounce between 0 and the maximum value. It sits between the board I/O and the counter instance in the top level.

Parameters:
WIDTH, 8, counter width; bounce limits are 0 and 2^WIDTH-1.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new key level (10 ms at 50 MHz).
TICK_CYCLES, 12500000, cycles between count pulses in run mode (4 Hz at 50 MHz).

Ports:
CLOCK  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
key_up_n  in  1  up button, active-low, asynchronous to CLOCK.
key_down_n  in  1  down button, active-low, asynchronous to CLOCK.
mode_run  in  1  0 = step mode, 1 = run mode (switch, synchronized internally).
bounce  in  1  1 = auto-reverse at limits in run mode (switch, synchronized internally).
count_in  in  WIDTH  current counter value, fed back from the counter.
cnt_enable  out  1  single-cycle count pulse to the counter.
cnt_up_down  out  1  direction to the counter: 1 = up, 0 = down.
cnt_clear_n  out  1  active-low clear to the counter; 1-cycle pulse.
state  out  2  FSM state for LEDs: IDLE=0, RUN=1, CLEAR=2, HOLD=3.

Behaviour:
- Reset (async, reset=0) sets: cnt_enable=0, cnt_up_down=1, cnt_clear_n=1, state=IDLE, prescaler=0, both debounced levels = released, all sync flops = released/0.
- Synchronization: every async input passes through a 2-FF synchronizer.
- Debounce: a debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
- Press event: a 1-cycle pulse on a released->pressed transition of a debounced level. Total latency from pin to event is DEBOUNCE_CYCLES+3 cycles.
- Both-held condition: both debounced levels pressed. This condition overrides every other transition.
- IDLE:
  - Both-held -> CLEAR.
  - Up press with mode_run=0: one cnt_enable pulse with cnt_up_down=1 in the next cycle. Down press is the same with cnt_up_down=0. State stays IDLE.
  - Up/down press with mode_run=1: set direction, clear prescaler -> RUN. No pulse on entry.
- RUN:
  - Prescaler counts 0..TICK_CYCLES-1; cnt_enable pulses for 1 cycle when it wraps. First pulse comes TICK_CYCLES cycles after entry.
  - Press of the key matching the current direction -> IDLE; no further pulses.
  - Press of the opposite key: flip direction, clear prescaler, stay in RUN.
  - mode_run=0 -> IDLE on the next cycle.
  - Both-held -> CLEAR.
- Bounce: with bounce=1, at a tick where (dir=up and count_in=2^WIDTH-1) or (dir=down and count_in=0), flip cnt_up_down in the same cycle the pulse is issued, so the pulse counts away from the limit.
- Without bounce, the counter wraps naturally; the controller takes no action.
- CLEAR: cnt_clear_n=0 for exactly 1 cycle, cnt_enable=0, then -> HOLD.
- HOLD: no outputs active; -> IDLE once both debounced levels are released. Press events occurring in HOLD are discarded.
- Invariant: cnt_enable is never 1 in a cycle where cnt_clear_n=0.
- cnt_up_down holds its last value in IDLE.
- Reset mid-RUN or mid-CLEAR: all outputs take their reset values immediately, with no pulse.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=8, WIDTH=8.)
1. Step mode, press key_up_n low for 20 cycles -> exactly one cnt_enable pulse with cnt_up_down=1, 7 cycles after the falling edge. A glitch of 3 cycles low -> no pulse.
2. Run mode, press up then release -> state=1, pulses every 8 cycles (first at entry+8). Press up again -> state=0, no further pulses.
3. Run up with bounce=1, count_in=255 at a tick -> that pulse carries cnt_up_down=0. Then count_in=0 at a later tick -> pulse carries cnt_up_down=1.
4. Run up, press down (up released) -> direction 0, next pulse 8 cycles after the reversal; state stays 1.
5. Hold both keys -> cnt_clear_n low for exactly 1 cycle with cnt_enable=0, state 2 then 3. Stays 3 until both released, then returns to 0.
6. Assert reset low mid-RUN, asynchronously between clock edges -> outputs go to 0/1/1 and state 0 without a clock edge. No pulses after release until a new key press.
